seg_scan_controller: RTL and testbench

- Time-multiplexes one shared excess-3 seven-segment decoder across NUM_DIGITS common-anode digits.
- Holds a double-buffered digit frame and drives the decoder's 3-bit excess-3 code input.
- Drives active-low digit anodes, inserting a blanking gap between digits so no ghosting occurs.
- Sits between the arithmetic result registers and the board's display pins.

---
 rtl/seg_scan_controller.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: drives one shared excess-3 seven-segment decoder
// across NUM_DIGITS common-anode digits. Each digit is preceded by a
// blanking gap with all anodes off, which prevents ghosting. The frame is
// double-buffered: loads made while scanning land in a shadow frame, and the
// shadow frame becomes active only at the end of a complete frame.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [3*NUM_DIGITS-1:0] digits_in,
    output logic [2:0]              num,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [2:0]    XS3_ZERO   = 3'b011;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                       state, nstate;
    logic [IW-1:0]                idx, nidx;
    logic [CW-1:0]                cnt, ncnt;
    logic                         commit;

    logic [NUM_DIGITS-1:0][2:0]   active, shadow;
    logic [NUM_DIGITS-1:0][2:0]   nactive, nshadow;
    logic                         npending;

    logic [NUM_DIGITS-1:0]        nan;
    logic [2:0]                   nnum;
    logic                         nfd;

    // Scan sequencing: IDLE -> BLANK -> SHOW -> BLANK ... with per-state
    // cycle counter and digit index. Dropping enable aborts straight to IDLE.
    always_comb begin
        nstate = state;
        nidx   = idx;
        ncnt   = cnt + 1'b1;
        commit = 1'b0;
        case (state)
            IDLE: begin
                nidx = '0;
                ncnt = '0;
                if (enable)
                    nstate = BLANK;
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nstate = SHOW;
                    ncnt   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    nstate = BLANK;
                    ncnt   = '0;
                    if (idx == IDX_LAST) begin
                        nidx   = '0;
                        commit = 1'b1;
                    end else begin
                        nidx = idx + 1'b1;
                    end
                end
            end
            default: begin
                nstate = IDLE;
                nidx   = '0;
                ncnt   = '0;
            end
        endcase
        if (!enable) begin
            nstate = IDLE;
            nidx   = '0;
            ncnt   = '0;
            commit = 1'b0;
        end
    end

    // Frame buffering. The end-of-frame swap applies first, so a load on the
    // commit cycle overrides any older shadow data.
    always_comb begin
        nactive  = active;
        nshadow  = shadow;
        npending = pending;
        if (commit && pending) begin
            nactive  = shadow;
            npending = 1'b0;
        end
        if (load) begin
            if (state == IDLE || commit) begin
                nactive  = digits_in;
                nshadow  = digits_in;
                npending = 1'b0;
            end else begin
                nshadow  = digits_in;
                npending = 1'b1;
            end
        end
    end

    // Output decode from the next state, so that an/num/frame_done are
    // registered and line up with the state they describe.
    always_comb begin
        nan = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            nan[i] = !((nstate == SHOW) && (nidx == IW'(i)));
        nnum = nactive[nidx];
        nfd  = (nstate == SHOW) && (nidx == IDX_LAST) && (ncnt == SHOW_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= nstate;
            idx   <= nidx;
            cnt   <= ncnt;
        end
    end

    // Active/shadow frame storage and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= {NUM_DIGITS{XS3_ZERO}};
            shadow  <= {NUM_DIGITS{XS3_ZERO}};
            pending <= 1'b0;
        end else begin
            active  <= nactive;
            shadow  <= nshadow;
            pending <= npending;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            num        <= XS3_ZERO;
            frame_done <= 1'b0;
        end else begin
            an         <= nan;
            num        <= nnum;
            frame_done <= nfd;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller. The reference model tracks only "cycles
// since scanning started" plus the two frames. It derives the lit digit and
// the blank/show phase arithmetically from that count. Expected outputs are
// queued per cycle and a negedge monitor compares them.
module tb_seg_scan_controller;

    localparam int N    = 4;
    localparam int S    = 4;
    localparam int B    = 2;
    localparam int SLOT = B + S;
    localparam int P    = N * SLOT;

    logic           clk = 1'b0;
    logic           rst, enable, load;
    logic [3*N-1:0] digits_in;
    logic [2:0]     num;
    logic [N-1:0]   an;
    logic           pending, frame_done;

    always #5 clk = ~clk;

    seg_scan_controller #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
        .num(num), .an(an), .pending(pending), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [N-1:0] x_an;
        logic [2:0]   x_num;
        logic         x_pend;
        logic         x_fd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit         m_scan = 1'b0;
    int         m_t    = 0;
    logic [2:0] m_act[N];
    logic [2:0] m_sh[N];
    bit         m_pend = 1'b0;

    function automatic int cur_digit();
        return ((m_t - 1) % P) / SLOT;
    endfunction

    function automatic bit cur_blank();
        return ((m_t - 1) % SLOT) < B;
    endfunction

    function automatic bit cur_fd();
        return m_scan && (m_t % P == 0);
    endfunction

    function automatic logic [3*N-1:0] rnd();
        logic [31:0] v;
        v = $urandom;
        return v[3*N-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, queue expectation.
    task automatic step(input bit r, input bit e, input bit l, input logic [3*N-1:0] d);
        exp_t ex;
        bit   commit;
        rst = r; enable = e; load = l; digits_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_scan = 1'b0; m_t = 0; m_pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_act[i] = 3'b011;
                m_sh[i]  = 3'b011;
            end
        end else begin
            commit = cur_fd() && e;
            if (commit && m_pend) begin
                for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
                m_pend = 1'b0;
            end
            if (l) begin
                if (!m_scan || commit) begin
                    for (int i = 0; i < N; i++) begin
                        m_act[i] = d[3*i +: 3];
                        m_sh[i]  = d[3*i +: 3];
                    end
                    m_pend = 1'b0;
                end else begin
                    for (int i = 0; i < N; i++) m_sh[i] = d[3*i +: 3];
                    m_pend = 1'b1;
                end
            end
            if (!e) begin
                m_scan = 1'b0; m_t = 0;
            end else if (m_scan) begin
                m_t++;
            end else begin
                m_scan = 1'b1; m_t = 1;
            end
        end
        ex.x_an  = '1;
        ex.x_num = m_act[0];
        if (m_scan) begin
            ex.x_num = m_act[cur_digit()];
            if (!cur_blank()) ex.x_an[cur_digit()] = 1'b0;
        end
        ex.x_pend = m_pend;
        ex.x_fd   = cur_fd();
        q.push_back(ex);
    endtask

    // Advance with enable high until the model reaches the requested point.
    task automatic run_to(input int dg, input bit want_fd);
        int k;
        for (k = 0; k < 200; k++) begin
            if (want_fd ? cur_fd() : (m_scan && cur_digit() == dg && !cur_blank())) break;
            step(1'b0, 1'b1, 1'b0, rnd());
        end
        if (k == 200) begin
            total++;
            bad++;
            $display("FAIL run_to: target digit %0d fd %0d not reached, got t=%0d expected reach", dg, want_fd, m_t);
        end
    endtask

    // monitor: pop expectation each cycle and compare against the DUT
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("an", 32'(an), 32'(e.x_an));
            check("num", 32'(num), 32'(e.x_num));
            check("pending", 32'(pending), 32'(e.x_pend));
            check("frame_done", 32'(frame_done), 32'(e.x_fd));
            check("an_onehot", 32'($countones(~an) <= 1), 32'(1));
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0;
        // reset dominates enable and load
        step(1'b1, 1'b1, 1'b1, rnd());
        step(1'b1, 1'b1, 1'b1, rnd());
        // load in IDLE, then scan two full frames
        step(1'b0, 1'b0, 1'b1, {3'b100, 3'b101, 3'b110, 3'b111});
        step(1'b0, 1'b0, 1'b0, rnd());
        repeat (50) step(1'b0, 1'b1, 1'b0, rnd());
        // mid-frame load during digit 1
        run_to(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, '0);
        repeat (40) step(1'b0, 1'b1, 1'b0, rnd());
        // shadow load, then a load on the commit cycle overrides it
        run_to(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, {N{3'b001}});
        run_to(0, 1'b1);
        step(1'b0, 1'b1, 1'b1, {N{3'b010}});
        repeat (30) step(1'b0, 1'b1, 1'b0, rnd());
        // enable drop during digit 2, then re-enable
        run_to(2, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, rnd());
        repeat (30) step(1'b0, 1'b1, 1'b0, rnd());
        // pending shadow survives an enable drop
        run_to(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, rnd());
        run_to(2, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, rnd());
        repeat (40) step(1'b0, 1'b1, 1'b0, rnd());
        // reset mid-SHOW of digit 3 with pending set
        run_to(1, 1'b0);
        step(1'b0, 1'b1, 1'b1, rnd());
        run_to(3, 1'b0);
        step(1'b1, 1'b1, 1'b0, rnd());
        repeat (3) step(1'b0, 1'b0, 1'b0, rnd());
        // randomized traffic
        repeat (800)
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 92,
                 $urandom_range(0, 99) < 6, rnd());
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
